// File: rtl/ssd_mux_if.sv
// Signal bundle between a display controller (master) and the ssd_mux driver (slave).
// Carries the staged digit data and brightness in, and the board pin drives out.
interface ssd_mux_if #(
    parameter int NUM_DIGITS = 4,
    parameter int BRIGHT_W   = 4
);
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic                    load;
    logic [BRIGHT_W-1:0]     brightness;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_done;

    modport master (
        output digits_in, dp_in, blank_in, load, brightness,
        input  seg, dp, an, frame_done
    );

    modport slave (
        input  digits_in, dp_in, blank_in, load, brightness,
        output seg, dp, an, frame_done
    );
endinterface

// File: rtl/ssd_mux.sv
// Time-multiplexed seven-segment driver with frame-aligned shadow update,
// PWM brightness, anti-ghosting guard interval and selectable pin polarity.
module ssd_mux #(
    parameter int NUM_DIGITS       = 4,
    parameter int SLOT_CYC_LOG2    = 17,
    parameter int BRIGHT_W         = 4,
    parameter int GUARD_CYC        = 4,
    parameter bit ANODE_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
    input logic      clk,
    input logic      rst,
    ssd_mux_if.slave bus
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [SLOT_CYC_LOG2-1:0] SLOT_MAX = '1;
    localparam logic [SLOT_CYC_LOG2-1:0] GUARD    = SLOT_CYC_LOG2'(GUARD_CYC);
    localparam logic [NUM_DIGITS-1:0]    AN_OFF   = {NUM_DIGITS{ANODE_ACTIVE_LOW}};
    localparam logic [6:0]               SEG_OFF  = {7{SEG_ACTIVE_LOW}};

    logic [SLOT_CYC_LOG2-1:0] slot_cnt;
    logic [IDX_W-1:0]         digit_idx;
    logic                     pending_valid;
    logic [4*NUM_DIGITS-1:0]  pend_digits;
    logic [NUM_DIGITS-1:0]    pend_dp;
    logic [NUM_DIGITS-1:0]    pend_blank;
    logic [4*NUM_DIGITS-1:0]  act_digits;
    logic [NUM_DIGITS-1:0]    act_dp;
    logic [NUM_DIGITS-1:0]    act_blank;

    logic                     slot_end;
    logic                     frame_end;
    logic                     lit;
    logic [NUM_DIGITS-1:0]    sel;
    logic [3:0]               cur_nib;
    logic                     cur_dp;
    logic                     cur_blank;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        s = 7'b0000000;
        case (nib)
            4'h0: s = 7'b0111111;
            4'h1: s = 7'b0000110;
            4'h2: s = 7'b1011011;
            4'h3: s = 7'b1001111;
            4'h4: s = 7'b1100110;
            4'h5: s = 7'b1101101;
            4'h6: s = 7'b1111101;
            4'h7: s = 7'b0000111;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1101111;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b1111100;
            4'hC: s = 7'b0111001;
            4'hD: s = 7'b1011110;
            4'hE: s = 7'b1111001;
            4'hF: s = 7'b1110001;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Compare-based select keeps the mux clean for non-power-of-two digit counts.
    always_comb begin
        sel       = '0;
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (digit_idx == IDX_W'(k)) begin
                sel[k]    = 1'b1;
                cur_nib   = act_digits[4*k +: 4];
                cur_dp    = act_dp[k];
                cur_blank = act_blank[k];
            end
        end
    end

    assign slot_end  = (slot_cnt == SLOT_MAX);
    assign frame_end = slot_end && (digit_idx == LAST_IDX);
    assign lit       = !cur_blank && (slot_cnt >= GUARD)
                       && (slot_cnt[SLOT_CYC_LOG2-1 -: BRIGHT_W] <= bus.brightness);

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt       <= '0;
            digit_idx      <= '0;
            pending_valid  <= 1'b0;
            pend_digits    <= '0;
            pend_dp        <= '0;
            pend_blank     <= '1;
            act_digits     <= '0;
            act_dp         <= '0;
            act_blank      <= '1;
            bus.an         <= AN_OFF;
            bus.seg        <= SEG_OFF;
            bus.dp         <= SEG_ACTIVE_LOW;
            bus.frame_done <= 1'b0;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
            if (slot_end) begin
                digit_idx <= (digit_idx == LAST_IDX) ? '0 : digit_idx + 1'b1;
            end
            if (frame_end && pending_valid) begin
                act_digits    <= pend_digits;
                act_dp        <= pend_dp;
                act_blank     <= pend_blank;
                pending_valid <= 1'b0;
            end
            // A load in the boundary cycle lands after the clear, so it waits a frame.
            if (bus.load) begin
                pend_digits   <= bus.digits_in;
                pend_dp       <= bus.dp_in;
                pend_blank    <= bus.blank_in;
                pending_valid <= 1'b1;
            end
            bus.an         <= lit ? (sel ^ AN_OFF) : AN_OFF;
            bus.seg        <= lit ? (hex_to_seg(cur_nib) ^ SEG_OFF) : SEG_OFF;
            bus.dp         <= lit ? (cur_dp ^ SEG_ACTIVE_LOW) : SEG_ACTIVE_LOW;
            bus.frame_done <= frame_end;
        end
    end
endmodule

// File: doc/ssd_mux.md
Name: ssd_mux

Overview:
- Parametrised time-multiplexed seven-segment display driver. It is the successor to the fixed 4-digit display driver and feeds board anode and cathode pins directly.
- Takes NUM_DIGITS hex nibbles, plus per-digit decimal-point and blank masks, through a load-strobed shadow register. Updates are applied only at frame boundaries, so the display never tears.
- Adds PWM brightness, an anti-ghosting guard interval at each digit switch, and selectable pin polarity.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8)
SLOT_CYC_LOG2, 17, log2 of clock cycles per digit slot (100 MHz -> ~763 Hz/digit)
BRIGHT_W, 4, brightness control width; must be <= SLOT_CYC_LOG2
GUARD_CYC, 4, cycles at start of each slot with all anodes off; must be < 2^(SLOT_CYC_LOG2-BRIGHT_W)
ANODE_ACTIVE_LOW, 1, 1 = an driven low to enable a digit
SEG_ACTIVE_LOW, 1, 1 = seg/dp driven low to light a segment

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
digits_in  in  4*NUM_DIGITS  hex nibbles; digit k = digits_in[4k+3:4k]; digit 0 is rightmost / an[0]
dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
blank_in  in  NUM_DIGITS  1 = digit dark
load  in  1  stage digits_in/dp_in/blank_in into the pending register
brightness  in  BRIGHT_W  duty level; all-ones = full on, 0 = 1/2^BRIGHT_W
seg  out  7  segments {g,f,e,d,c,b,a}, seg[0] = a
dp  out  1  decimal point
an  out  NUM_DIGITS  anode enables
frame_done  out  1  one-cycle pulse per completed frame

Behaviour:
- Reset (sync, priority over everything):
  - slot_cnt = 0, digit_idx = 0, pending_valid = 0.
  - Active digits = 0, active dp = 0, active blank = all ones.
  - an, seg and dp all at their inactive level; frame_done = 0.
  - Reset mid-slot or mid-load discards all staged data.
- Slot counter:
  - slot_cnt is SLOT_CYC_LOG2 bits and free-runs.
  - When it wraps from max to 0, digit_idx advances, wrapping NUM_DIGITS-1 -> 0.
- Frame boundary = the cycle where slot_cnt == max and digit_idx == NUM_DIGITS-1. In that cycle:
  - If pending_valid, the active set is loaded from pending and pending_valid is cleared.
  - frame_done is asserted on the next cycle, coinciding with digit_idx == 0.
- Load:
  - load = 1 captures the inputs into pending and sets pending_valid.
  - Repeated loads before a boundary: the last one wins.
  - A load in the boundary cycle itself is staged only and applied at the following boundary.
  - brightness is not shadowed; it is sampled live every cycle.
- Digit enable: lit = !active_blank[digit_idx] AND slot_cnt >= GUARD_CYC AND slot_cnt[SLOT_CYC_LOG2-1 -: BRIGHT_W] <= brightness.
- Outputs:
  - an is one-hot at digit_idx when lit, otherwise all inactive.
  - seg and dp are driven from the active nibble and dp of digit_idx whenever lit. When not lit they are inactive.
  - All outputs are registered, with 1-cycle latency from the slot_cnt/digit_idx state.
- Polarity: each output is inverted per ANODE_ACTIVE_LOW / SEG_ACTIVE_LOW relative to the active-high values below.
- Hex decode, active-high {g..a}:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
- NUM_DIGITS = 1: digit_idx is held at 0 and every slot end is a frame boundary.

Test Plan (NUM_DIGITS=4, SLOT_CYC_LOG2=4, BRIGHT_W=2, GUARD_CYC=1, active-low):
- Reset, then run 200 cycles with no load -> an = 1111, seg = 1111111, dp = 1 throughout; frame_done pulses every 64 cycles.
- load with digits_in = 16'h8A30, blank_in = 0, dp_in = 4'b0010, brightness = 3 -> from the next frame:
  - an cycles 1110, 1101, 1011, 0111.
  - seg per digit is 1000000 (0), 0110000 (3), 0001000 (A), 0000000 (8).
  - dp = 0 only while an = 1101.
  - Each digit is off for the first cycle of its slot (guard) and on for 15 cycles.
- brightness = 0 -> each digit lit only while slot_cnt is 1..3 (3 cycles per 16); brightness = 2 -> lit for slot_cnt 1..11.
- Two loads mid-frame (digits_in 16'h1111, then 16'h2222) -> the frame in progress still shows the old value; the next frame shows 2222 only.
- load asserted exactly in the boundary cycle -> that data appears one full frame later, not immediately.
- Assert rst mid-slot while an = 1011 -> the cycle after rst, an = 1111; staged data is lost and the display stays dark until a new load plus boundary.
